// File: rtl/dac_trig_sched.sv
// Multi-channel DAC trigger scheduler.
// On start, latches a shot program and issues shot_count trigger pulses of
// width W = max(trig_width,1) to every enabled channel, rising edges P apart
// (P = max(shot_period, W+1)). It then waits for the enabled channels'
// busy (loopback_valid) to drop before pulsing done.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   start, abort    : single-cycle commands (abort wins, start only in IDLE)
//   shot_count      : pulses per run        (latched at start)
//   shot_period     : cycles between rises  (latched at start)
//   trig_width      : trigger high time     (latched at start)
//   ch_enable       : channel mask          (latched at start)
//   ch_busy         : per-channel busy from the channel controllers
//   trigger_out     : per-channel trigger
//   busy            : any state but IDLE
//   shot_idx        : rising edges issued in current/last run
//   done, aborted   : one-cycle completion / abort pulses
//   overrun         : sticky, enabled channel busy at a later trigger rise
module dac_trig_sched #(
    parameter int unsigned NUM_CH = 8,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned WID_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  shot_count,
    input  logic [CNT_W-1:0]  shot_period,
    input  logic [WID_W-1:0]  trig_width,
    input  logic [NUM_CH-1:0] ch_enable,
    input  logic [NUM_CH-1:0] ch_busy,
    output logic [NUM_CH-1:0] trigger_out,
    output logic              busy,
    output logic [CNT_W-1:0]  shot_idx,
    output logic              done,
    output logic              aborted,
    output logic              overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PULSE,
        S_GAP,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt_lat;
    logic [CNT_W-1:0]  p_lat;
    logic [CNT_W-1:0]  w_lat;
    logic [CNT_W-1:0]  pc;
    logic [NUM_CH-1:0] en_lat;
    logic              first_cyc;

    logic [CNT_W-1:0]  w_eff;
    logic [CNT_W-1:0]  p_eff;

    // Effective width and period from the live inputs; only used at latch time
    always_comb begin
        w_eff = (trig_width == '0) ? CNT_W'(1) : CNT_W'(trig_width);
        p_eff = (shot_period > w_eff) ? shot_period : (w_eff + CNT_W'(1));
    end

    // Scheduler FSM. pc loads P-1 at each rising edge and counts down once per
    // cycle, so the pulse ends when pc == P-W and the next rise follows pc == 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            cnt_lat     <= '0;
            p_lat       <= '0;
            w_lat       <= '0;
            pc          <= '0;
            en_lat      <= '0;
            first_cyc   <= 1'b0;
            trigger_out <= '0;
            busy        <= 1'b0;
            shot_idx    <= '0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            if (state != S_IDLE && abort) begin
                state       <= S_IDLE;
                trigger_out <= '0;
                busy        <= 1'b0;
                aborted     <= 1'b1;
                first_cyc   <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            cnt_lat  <= shot_count;
                            p_lat    <= p_eff;
                            w_lat    <= w_eff;
                            en_lat   <= ch_enable;
                            shot_idx <= '0;
                            overrun  <= 1'b0;
                            busy     <= 1'b1;
                            if (shot_count == '0) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end else begin
                                state       <= S_PULSE;
                                trigger_out <= ch_enable;
                                pc          <= p_eff - CNT_W'(1);
                                first_cyc   <= 1'b1;
                            end
                        end
                    end
                    S_PULSE: begin
                        first_cyc <= 1'b0;
                        pc        <= pc - CNT_W'(1);
                        // Shot bookkeeping on the first high cycle of each shot
                        if (first_cyc) begin
                            if (shot_idx != cnt_lat) begin
                                shot_idx <= shot_idx + CNT_W'(1);
                            end
                            if (shot_idx != '0 && (ch_busy & en_lat) != '0) begin
                                overrun <= 1'b1;
                            end
                        end
                        if (pc == (p_lat - w_lat)) begin
                            state       <= S_GAP;
                            trigger_out <= '0;
                        end
                    end
                    S_GAP: begin
                        if (pc == '0) begin
                            if (shot_idx == cnt_lat) begin
                                state <= S_DRAIN;
                            end else begin
                                state       <= S_PULSE;
                                trigger_out <= en_lat;
                                pc          <= p_lat - CNT_W'(1);
                                first_cyc   <= 1'b1;
                            end
                        end else begin
                            pc <= pc - CNT_W'(1);
                        end
                    end
                    // Trigger stays low so the channels can re-arm
                    S_DRAIN: begin
                        if ((ch_busy & en_lat) == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dac_trig_sched.sv
// Self-checking bench for dac_trig_sched: a run-relative timeline model
// checked every cycle, plus directed runs with hand-computed expectations.
module tb_dac_trig_sched;

    localparam int unsigned NUM_CH = 8;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned WID_W  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [CNT_W-1:0]  shot_count = '0;
    logic [CNT_W-1:0]  shot_period = '0;
    logic [WID_W-1:0]  trig_width = '0;
    logic [NUM_CH-1:0] ch_enable = '0;
    logic [NUM_CH-1:0] ch_busy = '0;
    logic [NUM_CH-1:0] trigger_out;
    logic              busy;
    logic [CNT_W-1:0]  shot_idx;
    logic              done;
    logic              aborted;
    logic              overrun;

    dac_trig_sched #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .WID_W(WID_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .shot_count(shot_count), .shot_period(shot_period),
        .trig_width(trig_width), .ch_enable(ch_enable), .ch_busy(ch_busy),
        .trigger_out(trigger_out), .busy(busy), .shot_idx(shot_idx),
        .done(done), .aborted(aborted), .overrun(overrun)
    );

    always #2 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp = n_cmp + 1;
        if (act != exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: a run is a timeline indexed by k (k=1 is the cycle
    // after start). Shot j rises at k = 1 + j*P and is high for W cycles;
    // the last gap ends at k = N*P, then drain, then one done cycle.
    typedef enum {M_IDLE, M_RUN, M_DRAIN, M_DONE} mph_t;
    mph_t        mph = M_IDLE;
    longint      m_k = 0, m_n = 0, m_p = 2, m_w = 1;
    logic [7:0]  m_en = '0;
    logic [7:0]  e_trig = '0;
    logic        e_busy = 1'b0, e_done = 1'b0, e_ab = 1'b0, e_ovr = 1'b0;
    longint      e_idx = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mph = M_IDLE;
            e_trig = '0; e_busy = 1'b0; e_done = 1'b0; e_ab = 1'b0;
            e_ovr = 1'b0; e_idx = 0;
        end else begin
            e_done = 1'b0;
            e_ab   = 1'b0;
            if (mph == M_IDLE) begin
                if (start && !abort) begin
                    m_n  = longint'(shot_count);
                    m_w  = (trig_width == '0) ? 1 : longint'(trig_width);
                    m_p  = (longint'(shot_period) > m_w) ? longint'(shot_period) : m_w + 1;
                    m_en = ch_enable;
                    e_idx = 0; e_ovr = 1'b0; e_busy = 1'b1;
                    if (m_n == 0) begin
                        mph = M_DONE; e_done = 1'b1;
                    end else begin
                        mph = M_RUN; m_k = 1; e_trig = m_en;
                    end
                end
            end else if (abort) begin
                mph = M_IDLE; e_trig = '0; e_busy = 1'b0; e_ab = 1'b1;
            end else begin
                case (mph)
                    M_RUN: begin
                        if ((m_k - 1) % m_p == 0) begin
                            if (m_k > 1 && (ch_busy & m_en) != 0) e_ovr = 1'b1;
                            if (e_idx < m_n) e_idx = e_idx + 1;
                        end
                        m_k = m_k + 1;
                        if (m_k > m_n * m_p) begin
                            mph = M_DRAIN; e_trig = '0;
                        end else begin
                            e_trig = (((m_k - 1) % m_p) < m_w) ? m_en : 8'h00;
                        end
                    end
                    M_DRAIN: begin
                        if ((ch_busy & m_en) == 0) begin
                            mph = M_DONE; e_done = 1'b1;
                        end
                    end
                    M_DONE: begin
                        mph = M_IDLE; e_busy = 1'b0;
                    end
                    default: mph = M_IDLE;
                endcase
            end
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        chk("trigger_out", longint'(trigger_out), longint'(e_trig));
        chk("busy",        longint'(busy),        longint'(e_busy));
        chk("shot_idx",    longint'(shot_idx),    e_idx);
        chk("done",        longint'(done),        longint'(e_done));
        chk("aborted",     longint'(aborted),     longint'(e_ab));
        chk("overrun",     longint'(overrun),     longint'(e_ovr));
    end

    // Run-relative event recorder for the directed checks
    int         t_start = 0;
    int         rises[$];
    int         hi_cnt = 0;
    int         busy_cnt = 0;
    int         done_at = -1;
    int         ab_at = -1;
    logic [7:0] prev_trig = '0;

    always @(negedge clk) begin
        if (trigger_out != '0 && prev_trig == '0) rises.push_back(cyc - t_start);
        if (trigger_out != '0) hi_cnt = hi_cnt + 1;
        if (busy) busy_cnt = busy_cnt + 1;
        if (done) done_at = cyc - t_start;
        if (aborted) ab_at = cyc - t_start;
        prev_trig = trigger_out;
    end

    function automatic int q_at(input int i);
        if (i < rises.size()) return rises[i];
        return -1;
    endfunction

    task automatic clr_mon();
        rises.delete();
        hi_cnt = 0; busy_cnt = 0; done_at = -1; ab_at = -1;
    endtask

    task automatic do_start(input int cnt, input int per, input int wid, input logic [7:0] en);
        @(posedge clk); #1;
        shot_count  = CNT_W'(cnt);
        shot_period = CNT_W'(per);
        trig_width  = WID_W'(wid);
        ch_enable   = en;
        start       = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        t_start = cyc - 1;
        clr_mon();
    endtask

    task automatic wait_end(input string nm, input int budget);
        int n;
        n = 0;
        while (done_at < 0 && ab_at < 0 && n < budget) begin
            @(posedge clk); #1;
            n = n + 1;
        end
        n_cmp = n_cmp + 1;
        if (done_at < 0 && ab_at < 0) begin
            n_err = n_err + 1;
            $display("FAIL %s timeout: no done/aborted within %0d cycles", nm, budget);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset with start held high
        rst = 1'b0; start = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst trigger_out", longint'(trigger_out), 0);
        chk("rst busy",        longint'(busy), 0);
        chk("rst shot_idx",    longint'(shot_idx), 0);
        chk("rst done",        longint'(done), 0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Basic train: P=10, W=2
        do_start(3, 10, 2, 8'h05);
        wait_end("t1", 100);
        chk("t1 rise0", q_at(0), 1);
        chk("t1 rise1", q_at(1), 11);
        chk("t1 rise2", q_at(2), 21);
        chk("t1 nrises", rises.size(), 3);
        chk("t1 high cycles", hi_cnt, 6);
        chk("t1 done_at", done_at, 32);
        chk("t1 shot_idx", longint'(shot_idx), 3);
        chk("t1 overrun", longint'(overrun), 0);

        // Period clamped to W+1 = 7
        do_start(2, 4, 6, 8'hFF);
        wait_end("t2", 100);
        chk("t2 rise0", q_at(0), 1);
        chk("t2 rise1", q_at(1), 8);
        chk("t2 high cycles", hi_cnt, 12);
        chk("t2 done_at", done_at, 16);

        // Channel 0 busy across the second rise, dropping at k=40
        do_start(3, 10, 2, 8'h05);
        while (cyc - t_start < 80 && done_at < 0) begin
            @(posedge clk); #1;
            if (cyc - t_start == 5)  ch_busy = 8'h01;
            if (cyc - t_start == 40) ch_busy = 8'h00;
        end
        ch_busy = 8'h00;
        wait_end("t3", 20);
        chk("t3 overrun", longint'(overrun), 1);
        chk("t3 rise2", q_at(2), 21);
        chk("t3 done_at", done_at, 41);

        // Abort in the second PULSE cycle of shot 2
        do_start(3, 10, 3, 8'h0F);
        while (cyc - t_start < 12) begin
            @(posedge clk); #1;
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("t4 aborted_at", ab_at, 13);
        chk("t4 done_at", done_at, -1);
        chk("t4 shot_idx", longint'(shot_idx), 2);
        chk("t4 high cycles", hi_cnt, 5);
        chk("t4 busy", longint'(busy), 0);
        do_start(1, 2, 1, 8'h80);
        wait_end("t4b", 20);
        chk("t4b done_at", done_at, 4);
        chk("t4b rise0", q_at(0), 1);

        // Zero shots, then start+abort together in IDLE
        do_start(0, 5, 5, 8'hFF);
        wait_end("t5", 10);
        chk("t5 done_at", done_at, 1);
        chk("t5 nrises", rises.size(), 0);
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        clr_mon();
        repeat (5) @(posedge clk);
        #1;
        chk("t5 busy cycles", busy_cnt, 0);
        chk("t5 high cycles", hi_cnt, 0);

        // Randomized runs with live config changes, stray starts and aborts
        for (int it = 0; it < 30; it++) begin
            int n;
            do_start(int'($urandom_range(0, 4)), int'($urandom_range(0, 12)),
                     int'($urandom_range(0, 5)), 8'($urandom));
            n = 0;
            while (done_at < 0 && ab_at < 0 && n < 300) begin
                ch_busy     = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
                abort       = ($urandom_range(0, 79) == 0);
                start       = ($urandom_range(0, 9) == 0);
                shot_count  = CNT_W'($urandom_range(0, 6));
                shot_period = CNT_W'($urandom);
                trig_width  = WID_W'($urandom);
                ch_enable   = 8'($urandom);
                @(posedge clk); #1;
                n = n + 1;
            end
            n_cmp = n_cmp + 1;
            if (done_at < 0 && ab_at < 0) begin
                n_err = n_err + 1;
                $display("FAIL random run %0d timeout", it);
            end
            start = 1'b0; ch_busy = 8'h00; abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
